// File: rtl/pipe_hazard_unit.sv
// Load-use hazard detection and EX operand forwarding control for the pipelined core.
// Tracks destination info for every in-flight instruction from EX (entry 0) to WB (entry DEPTH-1).
module pipe_hazard_unit #(
    parameter int AW       = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int SELW     = $clog2(DEPTH + 1),
    parameter int CNTW     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic            id_wr_en,
    input  logic [AW-1:0]   id_wr_addr,
    input  logic            id_is_load,
    output logic            stall,
    output logic [SELW-1:0] fwd_rs_sel,
    output logic [SELW-1:0] fwd_rt_sel,
    output logic [CNTW-1:0] stall_cnt
);

    logic [DEPTH-1:0]         v_q, v_d;
    logic [DEPTH-1:0]         we_q, we_d;
    logic [DEPTH-1:0]         ld_q, ld_d;
    logic [DEPTH-1:0][AW-1:0] addr_q, addr_d;
    logic [SELW-1:0]          rs_sel_q, rs_sel_d;
    logic [SELW-1:0]          rt_sel_q, rt_sel_d;
    logic [CNTW-1:0]          cnt_q, cnt_d;

    logic                     live;
    logic                     hazard;
    logic [DEPTH-1:0]         match_rs, match_rt;
    logic [SELW-1:0]          rs_sel_c, rt_sel_c;

    // Scanning from the oldest entry down lets the youngest matching producer win.
    always_comb begin
        live     = id_valid & ~flush;
        hazard   = 1'b0;
        rs_sel_c = '0;
        rt_sel_c = '0;
        for (int j = 0; j < DEPTH; j++) begin
            match_rs[j] = v_q[j] & we_q[j] & (addr_q[j] != '0) & (addr_q[j] == id_rs) & id_use_rs;
            match_rt[j] = v_q[j] & we_q[j] & (addr_q[j] != '0) & (addr_q[j] == id_rt) & id_use_rt;
        end
        for (int j = 0; j < LOAD_LAT; j++) begin
            if (ld_q[j] && (match_rs[j] || match_rt[j])) begin
                hazard = 1'b1;
            end
        end
        for (int j = DEPTH - 1; j >= 0; j--) begin
            if (match_rs[j]) begin
                rs_sel_c = SELW'(j + 1);
            end
            if (match_rt[j]) begin
                rt_sel_c = SELW'(j + 1);
            end
        end
        stall = live & hazard;
    end

    always_comb begin
        v_d      = v_q;
        we_d     = we_q;
        ld_d     = ld_q;
        addr_d   = addr_q;
        rs_sel_d = rs_sel_q;
        rt_sel_d = rt_sel_q;
        cnt_d    = cnt_q;
        if (!hold) begin
            for (int i = 1; i < DEPTH; i++) begin
                v_d[i]    = v_q[i-1];
                we_d[i]   = we_q[i-1];
                ld_d[i]   = ld_q[i-1];
                addr_d[i] = addr_q[i-1];
            end
            if (stall) begin
                v_d[0]    = 1'b0;
                we_d[0]   = 1'b0;
                ld_d[0]   = 1'b0;
                addr_d[0] = '0;
                rs_sel_d  = '0;
                rt_sel_d  = '0;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                v_d[0]    = live;
                we_d[0]   = id_wr_en & live;
                ld_d[0]   = id_is_load & live;
                addr_d[0] = id_wr_addr;
                rs_sel_d  = live ? rs_sel_c : '0;
                rt_sel_d  = live ? rt_sel_c : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q      <= '0;
            we_q     <= '0;
            ld_q     <= '0;
            addr_q   <= '0;
            rs_sel_q <= '0;
            rt_sel_q <= '0;
            cnt_q    <= '0;
        end else begin
            v_q      <= v_d;
            we_q     <= we_d;
            ld_q     <= ld_d;
            addr_q   <= addr_d;
            rs_sel_q <= rs_sel_d;
            rt_sel_q <= rt_sel_d;
            cnt_q    <= cnt_d;
        end
    end

    assign fwd_rs_sel = rs_sel_q;
    assign fwd_rt_sel = rt_sel_q;
    assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench for pipe_hazard_unit (DEPTH=3, LOAD_LAT=1), plus a narrow-counter
// instance sharing the same stimulus to exercise stall counter saturation.
module tb_pipe_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       hold, flush, id_valid;
    logic [4:0] id_rs, id_rt, id_wr_addr;
    logic       id_use_rs, id_use_rt, id_wr_en, id_is_load;

    logic        stall, stall_s;
    logic [1:0]  fwd_rs_sel, fwd_rt_sel, fwd_rs_sel_s, fwd_rt_sel_s;
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt_s;

    int tests  = 0;
    int errors = 0;

    typedef struct {
        string name;
        logic  e_stall;
        int    e_rs;
        int    e_rt;
        int    e_cnt;
    } exp_t;

    exp_t exp_q[$];

    pipe_hazard_unit #(.AW(5), .DEPTH(3), .LOAD_LAT(1), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
        .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .stall_cnt(stall_cnt)
    );

    pipe_hazard_unit #(.AW(5), .DEPTH(3), .LOAD_LAT(1), .CNTW(2)) dut_small (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
        .stall(stall_s), .fwd_rs_sel(fwd_rs_sel_s), .fwd_rt_sel(fwd_rt_sel_s), .stall_cnt(stall_cnt_s)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input string name, input logic r, input logic h, input logic f,
                                 input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic urs, input logic urt, input logic we,
                                 input logic [4:0] wa, input logic ld, input logic e_stall,
                                 input int e_rs, input int e_rt, input int e_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; hold = h; flush = f; id_valid = v;
        id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_wr_en = we; id_wr_addr = wa; id_is_load = ld;
        e.name = name; e.e_stall = e_stall; e.e_rs = e_rs; e.e_rt = e_rt; e.e_cnt = e_cnt;
        exp_q.push_back(e);
    endtask

    task automatic idle(input string name, input int e_rs, input int e_rt, input int e_cnt);
        applyStimulus(name, 0, 0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1'b0, e_rs, e_rt, e_cnt);
    endtask

    task automatic checkOutput(input exp_t e);
        int small_cnt;
        small_cnt = (e.e_cnt > 3) ? 3 : e.e_cnt;
        tests++;
        if (stall !== e.e_stall || int'(fwd_rs_sel) != e.e_rs || int'(fwd_rt_sel) != e.e_rt
            || int'(stall_cnt) != e.e_cnt || $isunknown({stall, fwd_rs_sel, fwd_rt_sel, stall_cnt})) begin
            errors++;
            $display("[TB] FAIL %s: got stall=%0b rs_sel=%0d rt_sel=%0d cnt=%0d, expected %0b %0d %0d %0d",
                     e.name, stall, fwd_rs_sel, fwd_rt_sel, stall_cnt, e.e_stall, e.e_rs, e.e_rt, e.e_cnt);
        end
        tests++;
        if (stall_s !== e.e_stall || int'(stall_cnt_s) != small_cnt || $isunknown(stall_cnt_s)) begin
            errors++;
            $display("[TB] FAIL %s_small: got stall=%0b cnt=%0d, expected %0b %0d",
                     e.name, stall_s, stall_cnt_s, e.e_stall, small_cnt);
        end
    endtask

    // Monitor: every negedge with a pending expectation is one DUT observation.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        rst = 1'b1; hold = 0; flush = 0; id_valid = 0;
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_wr_en = 0; id_wr_addr = 0; id_is_load = 0;

        applyStimulus("reset", 1, 0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1'b0, 0, 0, 0);

        // 1: ALU producer then consumer of rs
        applyStimulus("t1_prod", 0, 0, 0, 1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0, 1'b0, 0, 0, 0);
        applyStimulus("t1_cons", 0, 0, 0, 1, 5'd3, 5'd7, 1, 1, 1, 5'd8, 0, 1'b0, 0, 0, 0);
        idle("t1_fwd", 1, 0, 0);

        // 2: load-use on rt
        applyStimulus("t2_lw",    0, 0, 0, 1, 5'd1, 5'd0, 1, 0, 1, 5'd4,  1, 1'b0, 0, 0, 0);
        applyStimulus("t2_stall", 0, 0, 0, 1, 5'd9, 5'd4, 1, 1, 1, 5'd10, 0, 1'b1, 0, 0, 0);
        applyStimulus("t2_go",    0, 0, 0, 1, 5'd9, 5'd4, 1, 1, 1, 5'd10, 0, 1'b0, 0, 0, 1);
        idle("t2_fwd", 0, 2, 1);

        // 3: register 0 never matches
        applyStimulus("t3_prod0", 0, 0, 0, 1, 5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 1'b0, 0, 0, 1);
        applyStimulus("t3_cons0", 0, 0, 0, 1, 5'd0, 5'd0, 1, 0, 0, 5'd0, 0, 1'b0, 0, 0, 1);
        idle("t3_sel", 0, 0, 1);

        // 4: youngest producer wins; unrelated instruction pushes it one stage
        applyStimulus("t4_p1",   0, 0, 0, 1, 5'd0, 5'd0, 0, 0, 1, 5'd5, 0, 1'b0, 0, 0, 1);
        applyStimulus("t4_p2",   0, 0, 0, 1, 5'd0, 5'd0, 0, 0, 1, 5'd5, 0, 1'b0, 0, 0, 1);
        applyStimulus("t4_cons", 0, 0, 0, 1, 5'd5, 5'd6, 1, 1, 0, 5'd0, 0, 1'b0, 0, 0, 1);
        idle("t4_sel1", 1, 0, 1);
        applyStimulus("t4_q1",    0, 0, 0, 1, 5'd0, 5'd0, 0, 0, 1, 5'd5,  0, 1'b0, 0, 0, 1);
        applyStimulus("t4_q2",    0, 0, 0, 1, 5'd0, 5'd0, 0, 0, 1, 5'd5,  0, 1'b0, 0, 0, 1);
        applyStimulus("t4_unrel", 0, 0, 0, 1, 5'd0, 5'd0, 0, 0, 1, 5'd11, 0, 1'b0, 0, 0, 1);
        applyStimulus("t4_cons2", 0, 0, 0, 1, 5'd5, 5'd0, 1, 0, 0, 5'd0,  0, 1'b0, 0, 0, 1);
        idle("t4_sel2", 2, 0, 1);

        // 5: flush beats load-use hazard; flushed entry0 must be invalid
        applyStimulus("t5_lw",    0, 0, 0, 1, 5'd0,  5'd0, 0, 0, 1, 5'd6,  1, 1'b0, 0, 0, 1);
        applyStimulus("t5_flush", 0, 0, 1, 1, 5'd6,  5'd6, 1, 1, 1, 5'd12, 0, 1'b0, 0, 0, 1);
        applyStimulus("t5_after", 0, 0, 0, 1, 5'd12, 5'd6, 1, 1, 0, 5'd0,  0, 1'b0, 0, 0, 1);
        idle("t5_sel", 0, 2, 1);

        // 6: hold during stall, then asynchronous reset mid-stall
        applyStimulus("t6_lw", 0, 0, 0, 1, 5'd0, 5'd0, 0, 0, 1, 5'd7, 1, 1'b0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus("t6_hold", 0, 1, 0, 1, 5'd7, 5'd0, 1, 0, 1, 5'd13, 0, 1'b1, 0, 0, 1);
        end
        applyStimulus("t6_rst", 1, 1, 0, 1, 5'd7, 5'd0, 1, 0, 1, 5'd13, 0, 1'b0, 0, 0, 0);
        idle("t6_rel", 0, 0, 0);

        // Repeated load-use stalls: wide counter counts 1..4, 2-bit counter stops at 3
        for (int k = 1; k <= 4; k++) begin
            applyStimulus("sat_lw",    0, 0, 0, 1, 5'd0, 5'd0, 0, 0, 1, 5'd7, 1, 1'b0, (k == 1) ? 0 : 2, 0, k - 1);
            applyStimulus("sat_stall", 0, 0, 0, 1, 5'd7, 5'd0, 1, 0, 0, 5'd0, 0, 1'b1, 0, 0, k - 1);
            applyStimulus("sat_go",    0, 0, 0, 1, 5'd7, 5'd0, 1, 0, 0, 5'd0, 0, 1'b0, 0, 0, k);
        end
        idle("sat_end", 2, 0, 4);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            tests++;
            errors++;
            $display("[TB] FAIL drain: pending=%0d, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised hazard-detection and forwarding controller for the pipelined MIPS-subset core.
- Sits beside the ID stage. It keeps its own shift register of destination-register information for every in-flight instruction from EX to WB.
- It raises a load-use stall, generates registered per-operand forwarding selects for the EX-stage operand muxes, kills the ID instruction on a branch flush, and counts stall cycles.
- Replaces the unconditional, hazard-unaware pipeline-register clocking the core uses today.

Parameters:
- AW, 5: register address width (2**AW architectural registers; register 0 is hardwired zero).
- DEPTH, 3: number of tracked in-flight entries. Entry 0 is EX, entry DEPTH-1 is WB. Must be ≥2.
- LOAD_LAT, 1: number of youngest entries in which a load result is not yet forwardable. Must be in the range 1..DEPTH-1.
- SELW, $clog2(DEPTH+1): width of the forwarding selects.
- CNTW, 16: width of the stall counter.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- hold  in  1  global freeze (memory wait); all state is held.
- flush  in  1  branch taken in ID; kills the ID instruction.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  AW  source register A of the ID instruction.
- id_rt  in  AW  source register B of the ID instruction.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_wr_en  in  1  ID instruction writes a register.
- id_wr_addr  in  AW  destination register (already muxed by RegDst).
- id_is_load  in  1  ID instruction is lw.
- stall  out  1  combinational. While high: hold the PC and IF/ID, and insert a bubble into EX.
- fwd_rs_sel  out  SELW  registered select for the EX operand-A mux.
  - 0 = value from the register file.
  - k = forward bus k, i.e. the result of the instruction k stages ahead of EX. Bus DEPTH is the datapath's retired-result hold register.
- fwd_rt_sel  out  SELW  registered select for the EX operand-B mux; same encoding as fwd_rs_sel.
- stall_cnt  out  CNTW  saturating count of cycles with stall=1 and hold=0.

Behaviour:
- Entry contents: each of the DEPTH entries holds {v, we, addr, ld}.
- Reset (asynchronous on rst=1), values while rst is high:
  - all entries {0,0,0,0};
  - fwd_rs_sel=0, fwd_rt_sel=0;
  - stall_cnt=0;
  - stall evaluates to 0 because no entry is valid.
- Live ID instruction: live = id_valid & ~flush.
- Match definition: entry j matches operand X when all of the following hold:
  - v=1, we=1, addr≠0;
  - addr==id_X;
  - id_use_X=1.
- Stall condition: stall = live & (some entry j with j<LOAD_LAT, ld=1, matches rs or rt).
  - Evaluated combinationally in the same cycle.
  - flush forces stall=0.
- Forward select (computed at ID, registered at the edge the instruction enters EX):
  - fwd_X_sel = j+1 for the lowest j that matches; the youngest producer wins.
  - If no entry matches, fwd_X_sel = 0.
- Clock edge with hold=1: nothing changes (entries, selects, counter).
- Clock edge with hold=0, stall=0:
  - entry[i] <= entry[i-1] for i≥1;
  - entry0 <= {live, id_wr_en&live, id_wr_addr, id_is_load&live};
  - selects <= computed values if live, else 0.
- Clock edge with hold=0, stall=1:
  - entries shift as above, but entry0 <= bubble {0,0,0,0};
  - selects <= 0;
  - stall_cnt += 1, saturating at 2**CNTW-1.
- A load sits in entry 0 for exactly LOAD_LAT cycles before it becomes forwardable.
  - With LOAD_LAT=1, a dependent instruction immediately after lw stalls exactly 1 cycle, then enters EX with sel=2.
  - Back-to-back consumers never stall more than LOAD_LAT cycles per load.
- Register 0 never matches, for any producer.
- flush together with a hazard: flush wins. No stall, no count increment, and a bubble enters EX.
- hold together with stall: stall is still driven high, but nothing advances and the counter does not increment.
- Reset asserted mid-stall: in-flight state is discarded immediately and stall drops asynchronously.

Test Plan (DEPTH=3, LOAD_LAT=1):
1. add r3 (we=1, addr=3), then next cycle add reading rs=3 → stall=0 throughout; the cycle after the consumer is accepted, fwd_rs_sel=1 and fwd_rt_sel=0.
2. lw r4, then consumer with rt=4 → stall=1 for exactly 1 cycle, stall_cnt=1; consumer enters EX with fwd_rt_sel=2.
3. Producer writing r0, then consumer reading rs=0 → stall=0 and fwd_rs_sel=0.
4. Two producers of r5 in consecutive cycles, then consumer with rs=5 → fwd_rs_sel=1 (youngest wins); with one unrelated instruction inserted before the consumer → fwd_rs_sel=2.
5. lw r6, then consumer of r6 with flush=1 → stall=0, stall_cnt unchanged, selects=0, entry0 invalid.
6. Hazard present and hold=1 for 4 cycles → stall=1, stall_cnt unchanged; then rst pulse mid-stall → stall=0, selects=0, stall_cnt=0 asynchronously. Separately, preload stall_cnt to 0xFFFF, stall once more → stays at 0xFFFF.
